// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and command-header table for the
// 8080-style LCD frame writer.
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int DEF_H_RES = 320;
    localparam int DEF_V_RES = 240;

    localparam int         CMD_LEN  = 11;
    localparam logic [3:0] CMD_LAST = 4'(CMD_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        PIXEL = 2'd2
    } state_t;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } bus_byte_t;

    // Header byte at position idx: CASET window, PASET window, then RAMWR.
    function automatic bus_byte_t cmd_byte(input logic [3:0]  idx,
                                           input logic [15:0] x_max,
                                           input logic [15:0] y_max);
        bus_byte_t b;
        b = '{dc: 1'b1, data: 8'h00};
        case (idx)
            4'd0:    b = '{dc: 1'b0, data: CMD_CASET};
            4'd3:    b.data = x_max[15:8];
            4'd4:    b.data = x_max[7:0];
            4'd5:    b = '{dc: 1'b0, data: CMD_PASET};
            4'd8:    b.data = y_max[15:8];
            4'd9:    b.data = y_max[7:0];
            4'd10:   b = '{dc: 1'b0, data: CMD_RAMWR};
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// LCD 8080 parallel-bus pins; the frame writer drives them as master.
interface lcd_frame_writer_if;
    logic       lcd_cs_n;
    logic       lcd_dc;
    logic       lcd_wr_n;
    logic       lcd_rd_n;
    logic [7:0] lcd_data;

    modport master (output lcd_cs_n, lcd_dc, lcd_wr_n, lcd_rd_n, lcd_data);
    modport slave  (input  lcd_cs_n, lcd_dc, lcd_wr_n, lcd_rd_n, lcd_data);
endinterface

// File: rtl/lcd_byte_writer.sv
// Emits one bus byte per start: wr_n low WR_LOW cycles, then high WR_HIGH.
module lcd_byte_writer #(
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dc,
    input  logic [7:0] data_byte,
    output logic       lcd_wr_n,
    output logic [7:0] lcd_data,
    output logic       lcd_dc,
    output logic       byte_done
);
    localparam int BYTE_CYC = WR_LOW + WR_HIGH;
    localparam int CNT_W    = $clog2(BYTE_CYC);

    logic [CNT_W-1:0] cnt;
    logic             active;

    assign byte_done = active && (cnt == CNT_W'(BYTE_CYC - 1));

    // A start coinciding with byte_done reloads immediately, so bytes are gapless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            cnt      <= '0;
            lcd_wr_n <= 1'b1;
            lcd_data <= 8'h00;
            lcd_dc   <= 1'b1;
        end else if (start) begin
            active   <= 1'b1;
            cnt      <= '0;
            lcd_wr_n <= 1'b0;
            lcd_data <= data_byte;
            lcd_dc   <= dc;
        end else if (byte_done) begin
            active   <= 1'b0;
            cnt      <= '0;
            lcd_wr_n <= 1'b1;
        end else if (active) begin
            cnt      <= cnt + 1'b1;
            lcd_wr_n <= !(int'(cnt) + 1 < WR_LOW);
        end
    end

endmodule

// File: rtl/lcd_frame_writer.sv
// Streams one RGB565 frame to an ILI9341-class controller: window/RAMWR header,
// then x-fastest raster with coordinates leading the bus by one pixel.
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int H_RES   = DEF_H_RES,
    parameter int V_RES   = DEF_V_RES,
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic [15:0]         pixel_color,
    output logic [8:0]          pixel_x,
    output logic [8:0]          pixel_y,
    output logic                busy,
    output logic                frame_done,
    lcd_frame_writer_if.master  lcd
);
    localparam logic [8:0]  X_MAX = 9'(H_RES - 1);
    localparam logic [8:0]  Y_MAX = 9'(V_RES - 1);
    localparam logic [15:0] X_ARG = 16'(H_RES - 1);
    localparam logic [15:0] Y_ARG = 16'(V_RES - 1);

    state_t     state;
    logic [3:0] cmd_idx;
    logic       low_next;
    logic       last_px;
    logic       cs_n;
    logic [7:0] lo_hold;

    logic       bw_start;
    logic       bw_dc;
    logic [7:0] bw_byte;
    logic       byte_done;
    logic       capture;
    bus_byte_t  next_cmd;
    logic       wr_n_w;
    logic       dc_w;
    logic [7:0] data_w;

    assign next_cmd = cmd_byte(cmd_idx + 4'd1, X_ARG, Y_ARG);

    // Colour is sampled when RAMWR or a pixel's low byte finishes, unless the frame is over.
    assign capture = byte_done &&
                     ((state == CMD && cmd_idx == CMD_LAST) ||
                      (state == PIXEL && !low_next && !last_px));

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        bw_start = 1'b0;
        bw_dc    = 1'b1;
        bw_byte  = pixel_color[15:8];
        case (state)
            IDLE: if (frame_start) begin
                bw_start = 1'b1;
                bw_dc    = 1'b0;
                bw_byte  = CMD_CASET;
            end
            CMD: if (byte_done) begin
                bw_start = 1'b1;
                if (cmd_idx != CMD_LAST) begin
                    bw_dc   = next_cmd.dc;
                    bw_byte = next_cmd.data;
                end
            end
            PIXEL: if (byte_done) begin
                if (low_next) begin
                    bw_start = 1'b1;
                    bw_byte  = lo_hold;
                end else if (!last_px) begin
                    bw_start = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_idx    <= '0;
            low_next   <= 1'b0;
            last_px    <= 1'b0;
            lo_hold    <= 8'h00;
            pixel_x    <= '0;
            pixel_y    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cs_n       <= 1'b1;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (frame_start) begin
                    state    <= CMD;
                    busy     <= 1'b1;
                    cs_n     <= 1'b0;
                    cmd_idx  <= '0;
                    low_next <= 1'b0;
                    last_px  <= 1'b0;
                    pixel_x  <= '0;
                    pixel_y  <= '0;
                end
                CMD: if (byte_done) begin
                    if (cmd_idx == CMD_LAST) state <= PIXEL;
                    else                     cmd_idx <= cmd_idx + 4'd1;
                end
                PIXEL: if (byte_done) begin
                    if (low_next) begin
                        low_next <= 1'b0;
                    end else if (last_px) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        cs_n       <= 1'b1;
                        frame_done <= 1'b1;
                        last_px    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (capture) begin
                lo_hold  <= pixel_color[7:0];
                low_next <= 1'b1;
                if (pixel_x == X_MAX) begin
                    pixel_x <= '0;
                    if (pixel_y == Y_MAX) begin
                        pixel_y <= '0;
                        last_px <= 1'b1;
                    end else begin
                        pixel_y <= pixel_y + 9'd1;
                    end
                end else begin
                    pixel_x <= pixel_x + 9'd1;
                end
            end
        end
    end

    lcd_byte_writer #(
        .WR_LOW  (WR_LOW),
        .WR_HIGH (WR_HIGH)
    ) u_byte_writer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (bw_start),
        .dc        (bw_dc),
        .data_byte (bw_byte),
        .lcd_wr_n  (wr_n_w),
        .lcd_data  (data_w),
        .lcd_dc    (dc_w),
        .byte_done (byte_done)
    );

    assign lcd.lcd_cs_n = cs_n;
    assign lcd.lcd_rd_n = 1'b1;
    assign lcd.lcd_wr_n = wr_n_w;
    assign lcd.lcd_dc   = dc_w;
    assign lcd.lcd_data = data_w;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed bench: default-size DUT for header/first pixels/mid-frame reset,
// 4x3 DUT for whole-frame ordering, busy length and back-to-back frames.
module tb_lcd_frame_writer;
    import lcd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        frame_start_a, frame_start_b;
    logic [15:0] color_a, color_b;
    logic [8:0]  px_a, py_a, px_b, py_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [7:0]  idx_b;

    lcd_frame_writer_if lcd_a ();
    lcd_frame_writer_if lcd_b ();

    lcd_frame_writer u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start_a),
        .pixel_color (color_a),
        .pixel_x     (px_a),
        .pixel_y     (py_a),
        .busy        (busy_a),
        .frame_done  (done_a),
        .lcd         (lcd_a)
    );

    lcd_frame_writer #(.H_RES(4), .V_RES(3), .WR_LOW(1), .WR_HIGH(1)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start_b),
        .pixel_color (color_b),
        .pixel_x     (px_b),
        .pixel_y     (py_b),
        .busy        (busy_b),
        .frame_done  (done_b),
        .lcd         (lcd_b)
    );

    // Colour stage models
    assign color_a = (px_a == 9'd0 && py_a == 9'd0) ? 16'hF800 :
                     (px_a == 9'd1 && py_a == 9'd0) ? 16'h07E0 : 16'h001F;
    assign idx_b   = 8'(py_b) * 8'd4 + 8'(px_b);
    assign color_b = {8'h40 + idx_b, 8'h80 + idx_b};

    typedef struct {
        logic [7:0] d;
        logic       dc;
        logic [8:0] x;
        logic [8:0] y;
    } rec_t;

    rec_t q_a[$];
    rec_t q_b[$];
    int   busy_cnt_b = 0;
    int   done_cnt_b = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge lcd_a.lcd_wr_n) q_a.push_back('{lcd_a.lcd_data, lcd_a.lcd_dc, px_a, py_a});
    always @(posedge lcd_b.lcd_wr_n) q_b.push_back('{lcd_b.lcd_data, lcd_b.lcd_dc, px_b, py_b});

    always @(posedge clk) begin
        if (busy_b) busy_cnt_b++;
        if (done_b) done_cnt_b++;
    end

    logic [8:0] hdr_a [11] = '{9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F,
                               9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02C};
    logic [8:0] hdr_b [11] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h103,
                               9'h02B, 9'h100, 9'h100, 9'h100, 9'h102, 9'h02C};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input bit sel_b, input int n, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if ((sel_b ? q_b.size() : q_a.size()) >= n) break;
            tick();
        end
        check(tag, 32'((sel_b ? q_b.size() : q_a.size()) >= n), 32'd1);
    endtask

    task automatic wait_done_b(input int budget, input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = done_b;
        end
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic check_reset_a(input string pfx);
        check({pfx, "_cs_n"},  32'(lcd_a.lcd_cs_n), 32'd1);
        check({pfx, "_wr_n"},  32'(lcd_a.lcd_wr_n), 32'd1);
        check({pfx, "_rd_n"},  32'(lcd_a.lcd_rd_n), 32'd1);
        check({pfx, "_dc"},    32'(lcd_a.lcd_dc),   32'd1);
        check({pfx, "_data"},  32'(lcd_a.lcd_data), 32'h00);
        check({pfx, "_busy"},  32'(busy_a),         32'd0);
        check({pfx, "_done"},  32'(done_a),         32'd0);
        check({pfx, "_px"},    32'(px_a),           32'd0);
        check({pfx, "_py"},    32'(py_a),           32'd0);
    endtask

    initial begin
        int         n1, busy1;
        logic [8:0] px1, py1;

        rst_n = 1'b0;
        frame_start_a = 1'b0;
        frame_start_b = 1'b0;
        repeat (3) tick();

        // Reset state, both instances
        check_reset_a("rst_a");
        check("rst_b_cs_n", 32'(lcd_b.lcd_cs_n), 32'd1);
        check("rst_b_wr_n", 32'(lcd_b.lcd_wr_n), 32'd1);
        check("rst_b_busy", 32'(busy_b), 32'd0);
        check("rst_b_px",   32'(px_b),   32'd0);
        check("rst_b_py",   32'(py_b),   32'd0);
        q_a.delete();
        q_b.delete();
        repeat (4) tick();
        check("rst_no_wr_edges_a", 32'(q_a.size()), 32'd0);
        check("rst_no_wr_edges_b", 32'(q_b.size()), 32'd0);
        rst_n = 1'b1;
        tick();

        // Default-size header and first two pixels
        frame_start_a = 1'b1;
        tick();
        frame_start_a = 1'b0;
        check("a_e0_busy", 32'(busy_a),         32'd1);
        check("a_e0_cs_n", 32'(lcd_a.lcd_cs_n), 32'd0);
        check("a_e0_dc",   32'(lcd_a.lcd_dc),   32'd0);
        check("a_e0_data", 32'(lcd_a.lcd_data), 32'h2A);
        check("a_e0_wr_n", 32'(lcd_a.lcd_wr_n), 32'd0);
        wait_bytes(1'b0, 15, 300, "a_first15_timeout");
        for (int i = 0; i < 11; i++)
            check($sformatf("a_hdr%0d", i), 32'({q_a[i].dc, q_a[i].d}), 32'(hdr_a[i]));
        check("a_pix0_hi", 32'({q_a[11].dc, q_a[11].d}), 32'h1F8);
        check("a_pix0_lo", 32'({q_a[12].dc, q_a[12].d}), 32'h100);
        check("a_pix1_hi", 32'({q_a[13].dc, q_a[13].d}), 32'h107);
        check("a_pix1_lo", 32'({q_a[14].dc, q_a[14].d}), 32'h1E0);
        check("a_pix0_lead_x", 32'(q_a[11].x), 32'd1);
        check("a_pix0_lead_y", 32'(q_a[11].y), 32'd0);

        // Small frame with ignored mid-frame requests
        busy_cnt_b = 0;
        done_cnt_b = 0;
        q_b.delete();
        frame_start_b = 1'b1;
        tick();
        frame_start_b = 1'b0;
        repeat (8) tick();
        frame_start_b = 1'b1;
        repeat (3) tick();
        frame_start_b = 1'b0;
        repeat (20) tick();
        frame_start_b = 1'b1;
        tick();
        frame_start_b = 1'b0;
        check("b_busy_mid", 32'(busy_b), 32'd1);
        wait_done_b(200, "b_done1_timeout");

        // Request coincident with frame_done starts the next frame
        frame_start_b = 1'b1;
        n1    = q_b.size();
        busy1 = busy_cnt_b;
        px1   = px_b;
        py1   = py_b;
        tick();
        frame_start_b = 1'b0;
        check("b_done_single",  32'(done_b),         32'd0);
        check("b_f2_busy",      32'(busy_b),         32'd1);
        check("b_f2_data",      32'(lcd_b.lcd_data), 32'h2A);
        check("b_f2_dc",        32'(lcd_b.lcd_dc),   32'd0);
        check("b_f1_bytes",     32'(n1),             32'd35);
        check("b_f1_busy_cyc",  32'(busy1),          32'd70);
        check("b_f1_end_x",     32'(px1),            32'd0);
        check("b_f1_end_y",     32'(py1),            32'd0);
        for (int i = 0; i < 11; i++)
            check($sformatf("b_hdr%0d", i), 32'({q_b[i].dc, q_b[i].d}), 32'(hdr_b[i]));
        for (int i = 0; i < 12; i++) begin
            int k;
            k = 11 + 2 * i;
            check($sformatf("b_pix%0d_hi", i),  32'({q_b[k].dc, q_b[k].d}),     32'({1'b1, 8'(8'h40 + i)}));
            check($sformatf("b_pix%0d_lo", i),  32'({q_b[k+1].dc, q_b[k+1].d}), 32'({1'b1, 8'(8'h80 + i)}));
            check($sformatf("b_pix%0d_x", i),   32'(q_b[k].x), 32'((i + 1) % 4));
            check($sformatf("b_pix%0d_y", i),   32'(q_b[k].y), 32'(((i + 1) % 12) / 4));
        end
        wait_done_b(200, "b_done2_timeout");
        check("b_f2_bytes",    32'(q_b.size()), 32'd70);
        check("b_f2_busy_cyc", 32'(busy_cnt_b), 32'd140);
        tick();
        check("b_done_count",  32'(done_cnt_b),     32'd2);
        check("b_idle_busy",   32'(busy_b),         32'd0);
        check("b_idle_cs_n",   32'(lcd_b.lcd_cs_n), 32'd1);
        check("b_idle_wr_n",   32'(lcd_b.lcd_wr_n), 32'd1);

        // Reset mid-pixel while wr_n is low on the default-size instance
        for (int i = 0; i < 20; i++) begin
            if (lcd_a.lcd_wr_n == 1'b0) break;
            tick();
        end
        check("a_mid_wr_low",  32'(lcd_a.lcd_wr_n), 32'd0);
        check("a_mid_pixel",   32'(lcd_a.lcd_dc & busy_a), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_a("arst");
        q_a.delete();
        repeat (3) tick();
        check("arst_no_wr_edges", 32'(q_a.size()), 32'd0);
        rst_n = 1'b1;
        tick();
        frame_start_a = 1'b1;
        tick();
        frame_start_a = 1'b0;
        check("a_restart_data", 32'(lcd_a.lcd_data), 32'h2A);
        wait_bytes(1'b0, 11, 200, "a_restart_timeout");
        for (int i = 0; i < 11; i++)
            check($sformatf("a_rehdr%0d", i), 32'({q_a[i].dc, q_a[i].d}), 32'(hdr_a[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
